// File: rtl/plm_bank.sv
`default_nettype none
// ============================================================================
// Module   : plm_bank
// Brief    : Multi-port private local memory bank with zero-init sweep and
//            1-cycle registered, consumer-tagged responses.
// Revision : 1.0
// ============================================================================
module plm_bank #(
    parameter int ADDR_WIDTH  = 16,
    parameter int VALUE_WIDTH = 8,
    parameter int NCONSUMERS  = 16,
    parameter int NBANKS      = 4,
    parameter int NPORTS      = 2,
    localparam int CID_W           = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1,
    localparam int LA_W            = ADDR_WIDTH - $clog2(NBANKS),
    localparam int DEPTH           = 2**LA_W,
    localparam int PLM_INPUT_WIDTH = LA_W + VALUE_WIDTH + 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NPORTS-1:0]                       req_valid,
    input  logic [NPORTS-1:0][PLM_INPUT_WIDTH-1:0]  req_data,
    input  logic [NPORTS-1:0][CID_W-1:0]            req_cid,
    output logic                                    ready,
    output logic [NPORTS-1:0]                       resp_valid,
    output logic [NPORTS-1:0]                       resp_we,
    output logic [NPORTS-1:0][VALUE_WIDTH-1:0]      resp_value,
    output logic [NPORTS-1:0][CID_W-1:0]            resp_cid
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [LA_W-1:0] c_ptr_last = '1;

    state_t                                r_state;
    logic [LA_W-1:0]                       r_ptr;
    logic                                  r_ready;
    logic [NPORTS-1:0]                     r_resp_valid;
    logic [NPORTS-1:0]                     r_resp_we;
    logic [NPORTS-1:0][VALUE_WIDTH-1:0]    r_resp_value;
    logic [NPORTS-1:0][CID_W-1:0]          r_resp_cid;

    logic [VALUE_WIDTH-1:0]                mem [DEPTH];

    logic [LA_W-1:0]                       w_addr  [NPORTS];
    logic [VALUE_WIDTH-1:0]                w_value [NPORTS];
    logic [NPORTS-1:0]                     w_we;

    always_comb begin
        w_we = '0;
        for (int p = 0; p < NPORTS; p++) begin
            w_addr[p]  = req_data[p][PLM_INPUT_WIDTH-1 -: LA_W];
            w_value[p] = req_data[p][VALUE_WIDTH:1];
            w_we[p]    = req_data[p][0];
        end
    end

    // Storage has no reset; the sweep clears it. Later ports overwrite
    // earlier ones in the loop, so the highest writing port wins.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            mem[r_ptr] <= '0;
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                if (req_valid[p] && w_we[p]) begin
                    mem[w_addr[p]] <= w_value[p];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_INIT;
            r_ptr        <= '0;
            r_ready      <= 1'b0;
            r_resp_valid <= '0;
            r_resp_we    <= '0;
            r_resp_value <= '0;
            r_resp_cid   <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_ptr        <= r_ptr + 1'b1;
                    r_resp_valid <= '0;
                    if (r_ptr == c_ptr_last) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_resp_valid <= req_valid;
                    for (int p = 0; p < NPORTS; p++) begin
                        // Reads sample mem before this edge's writes land: read-first.
                        if (req_valid[p]) begin
                            r_resp_we[p]    <= w_we[p];
                            r_resp_value[p] <= w_we[p] ? w_value[p] : mem[w_addr[p]];
                            r_resp_cid[p]   <= req_cid[p];
                        end
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign ready      = r_ready;
    assign resp_valid = r_resp_valid;
    assign resp_we    = r_resp_we;
    assign resp_value = r_resp_value;
    assign resp_cid   = r_resp_cid;

endmodule
`default_nettype wire

// File: tb/tb_plm_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_plm_bank
// Brief    : Directed self-checking bench for plm_bank (DEPTH=64, 2 ports).
// Revision : 1.0
// ============================================================================
module tb_plm_bank;

    localparam int ADDR_WIDTH  = 8;
    localparam int VALUE_WIDTH = 8;
    localparam int NCONSUMERS  = 16;
    localparam int NBANKS      = 4;
    localparam int NPORTS      = 2;
    localparam int CID_W       = 4;
    localparam int LA_W        = 6;
    localparam int PIW         = LA_W + VALUE_WIDTH + 1;

    logic                                clk = 1'b0;
    logic                                reset;
    logic [NPORTS-1:0]                   req_valid;
    logic [NPORTS-1:0][PIW-1:0]          req_data;
    logic [NPORTS-1:0][CID_W-1:0]        req_cid;
    logic                                ready;
    logic [NPORTS-1:0]                   resp_valid;
    logic [NPORTS-1:0]                   resp_we;
    logic [NPORTS-1:0][VALUE_WIDTH-1:0]  resp_value;
    logic [NPORTS-1:0][CID_W-1:0]        resp_cid;

    int checks   = 0;
    int failures = 0;

    plm_bank #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .VALUE_WIDTH (VALUE_WIDTH),
        .NCONSUMERS  (NCONSUMERS),
        .NBANKS      (NBANKS),
        .NPORTS      (NPORTS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_cid    (req_cid),
        .ready      (ready),
        .resp_valid (resp_valid),
        .resp_we    (resp_we),
        .resp_value (resp_value),
        .resp_cid   (resp_cid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [5:0] addr, input logic [7:0] val,
                           input logic we, input logic [3:0] cid);
        req_valid[p] = 1'b1;
        req_data[p]  = {addr, val, we};
        req_cid[p]   = cid;
    endtask

    task automatic sweep_and_check(input string tag);
        for (int i = 1; i <= 64; i++) begin
            tick();
            check({tag, "_ready"}, 32'(ready), 32'(i == 64));
            check({tag, "_no_resp"}, 32'(resp_valid), 32'd0);
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_cid   = '0;
        #2;
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_resp_value", 32'(resp_value), 32'd0);
        check("reset_resp_cid", 32'(resp_cid), 32'd0);
        tick();
        tick();

        // Init sweep with requests asserted; they must be ignored.
        set_req(0, 6'd5, 8'd55, 1'b1, 4'd1);
        set_req(1, 6'd63, 8'd66, 1'b1, 4'd2);
        reset = 1'b0;
        sweep_and_check("init");
        req_valid = '0;

        set_req(0, 6'd63, 8'd0, 1'b0, 4'd3);
        set_req(1, 6'd5, 8'd0, 1'b0, 4'd7);
        tick();
        check("rd63_valid", 32'(resp_valid), 32'h3);
        check("rd63_we", 32'(resp_we[0]), 32'd0);
        check("rd63_value", 32'(resp_value[0]), 32'd0);
        check("rd63_cid", 32'(resp_cid[0]), 32'd3);
        check("rd5_value", 32'(resp_value[1]), 32'd0);
        req_valid = '0;

        // Write then read, port 0
        set_req(0, 6'd2, 8'd25, 1'b1, 4'd0);
        tick();
        check("wr2_valid", 32'(resp_valid), 32'h1);
        check("wr2_we", 32'(resp_we[0]), 32'd1);
        check("wr2_value", 32'(resp_value[0]), 32'd25);
        check("wr2_cid", 32'(resp_cid[0]), 32'd0);
        set_req(0, 6'd2, 8'd0, 1'b0, 4'd5);
        tick();
        check("rd2_valid", 32'(resp_valid), 32'h1);
        check("rd2_we", 32'(resp_we[0]), 32'd0);
        check("rd2_value", 32'(resp_value[0]), 32'd25);
        check("rd2_cid", 32'(resp_cid[0]), 32'd5);
        req_valid = '0;

        // Read-first collision
        set_req(0, 6'd7, 8'd9, 1'b1, 4'd0);
        tick();
        set_req(0, 6'd7, 8'd40, 1'b1, 4'd1);
        set_req(1, 6'd7, 8'd0, 1'b0, 4'd2);
        tick();
        check("rf_ack_value", 32'(resp_value[0]), 32'd40);
        check("rf_rd_we", 32'(resp_we[1]), 32'd0);
        check("rf_rd_value", 32'(resp_value[1]), 32'd9);
        check("rf_rd_cid", 32'(resp_cid[1]), 32'd2);
        req_valid = '0;
        set_req(1, 6'd7, 8'd0, 1'b0, 4'd2);
        tick();
        check("rf_after_valid", 32'(resp_valid), 32'h2);
        check("rf_after_value", 32'(resp_value[1]), 32'd40);
        req_valid = '0;

        // Write-write collision
        set_req(0, 6'd3, 8'd11, 1'b1, 4'd1);
        set_req(1, 6'd3, 8'd22, 1'b1, 4'd2);
        tick();
        check("ww_valid", 32'(resp_valid), 32'h3);
        check("ww_we", 32'(resp_we), 32'h3);
        check("ww_val0", 32'(resp_value[0]), 32'd11);
        check("ww_cid0", 32'(resp_cid[0]), 32'd1);
        check("ww_val1", 32'(resp_value[1]), 32'd22);
        check("ww_cid1", 32'(resp_cid[1]), 32'd2);
        req_valid = '0;
        set_req(0, 6'd3, 8'd0, 1'b0, 4'd4);
        tick();
        check("ww_rd_value", 32'(resp_value[0]), 32'd22);
        req_valid = '0;
        tick();
        check("idle_valid", 32'(resp_valid), 32'd0);
        check("idle_hold_value", 32'(resp_value[0]), 32'd22);
        check("idle_hold_cid", 32'(resp_cid[0]), 32'd4);

        // Streaming reads on port 1
        for (int i = 0; i < 16; i++) begin
            set_req(0, 6'(i), 8'(i + 100), 1'b1, 4'd0);
            tick();
        end
        req_valid = '0;
        for (int i = 0; i < 16; i++) begin
            set_req(1, 6'(i), 8'd0, 1'b0, 4'(i));
            tick();
            check("stream_valid", 32'(resp_valid[1]), 32'd1);
            check("stream_value", 32'(resp_value[1]), 32'(i + 100));
            check("stream_cid", 32'(resp_cid[1]), 32'(i));
        end
        req_valid = '0;
        tick();
        check("stream_end_valid", 32'(resp_valid), 32'd0);

        // Reset mid-run with a response in flight
        set_req(0, 6'd4, 8'd77, 1'b1, 4'd0);
        tick();
        set_req(0, 6'd4, 8'd0, 1'b0, 4'd6);
        tick();
        check("pre_rst_valid", 32'(resp_valid[0]), 32'd1);
        check("pre_rst_value", 32'(resp_value[0]), 32'd77);
        reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(resp_valid), 32'd0);
        check("async_rst_ready", 32'(ready), 32'd0);
        check("async_rst_value", 32'(resp_value), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        sweep_and_check("reinit");
        req_valid = '0;
        set_req(0, 6'd4, 8'd0, 1'b0, 4'd9);
        tick();
        check("post_rst_valid", 32'(resp_valid), 32'h1);
        check("post_rst_value", 32'(resp_value[0]), 32'd0);
        check("post_rst_cid", 32'(resp_cid[0]), 32'd9);
        req_valid = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/plm_bank.md
Name: plm_bank

Overview:
- One private local memory (PLM) bank with NPORTS independent access ports. It sits directly downstream of rr_scheduling_kernel and consumes the per-bank, per-port requests that the scheduler selects.
- Each selected request carries a bank-local address, a value, a write flag, a valid bit and the originating consumer id.
- The bank performs the read or write and returns a registered response tagged with the consumer id. The scheduler uses that response to complete the consumer's transaction.
- After reset the bank runs a zero-initialisation sweep and signals readiness when the sweep completes.

Parameters:
- ADDR_WIDTH, 16, global request address width.
- VALUE_WIDTH, 8, data width.
- NCONSUMERS, 16, number of consumers; sets the id width CID_W = $clog2(NCONSUMERS).
- NBANKS, 4, bank count; local address width LA_W = ADDR_WIDTH - $clog2(NBANKS).
- NPORTS, 2, access ports on this bank.
- Derived: DEPTH = 2**LA_W; PLM_INPUT_WIDTH = LA_W + VALUE_WIDTH + 1.

Ports:
- clk  in  1  clock, single domain.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NPORTS  per-port request valid.
- req_data  in  NPORTS x PLM_INPUT_WIDTH  per-port request word {local_addr[LA_W], value[VALUE_WIDTH], we} (MSB to LSB).
- req_cid  in  NPORTS x CID_W  per-port originating consumer id.
- ready  out  1  high once initialisation is complete.
- resp_valid  out  NPORTS  per-port response valid.
- resp_we  out  NPORTS  response is a write acknowledge (1) or read data (0).
- resp_value  out  NPORTS x VALUE_WIDTH  read data; for a write, the value that was written.
- resp_cid  out  NPORTS x CID_W  consumer id, echoed from the request.

Behaviour:
- Reset is asynchronous and active-high. On assertion: ready=0, resp_valid=0, resp_we=0, resp_value=0, resp_cid=0, FSM=INIT, init pointer=0.
- Reset asserted mid-operation aborts any sweep or access. Responses in flight are discarded and the sweep restarts from 0 after reset is released.
- FSM state INIT:
  - Each cycle writes 0 to mem[ptr], then ptr increments.
  - When ptr == DEPTH-1 has been written, the FSM moves to RUN on the next edge.
  - ready rises exactly DEPTH cycles after the first clk posedge with reset low.
  - req_valid is ignored in INIT: no memory access, no response.
- FSM state RUN:
  - ready=1. Remains in RUN until reset.
- Access in RUN (per port p, with req_valid[p]=1 at posedge N):
  - Write (we=1): mem[local_addr] <= value at edge N. At edge N+1 the bank drives resp_valid[p]=1, resp_we[p]=1, resp_value[p]=value, resp_cid[p]=req_cid[p].
  - Read (we=0): at edge N+1 the bank drives resp_valid[p]=1, resp_we[p]=0, resp_value[p]=mem[local_addr] as it was before edge N, resp_cid[p]=req_cid[p].
  - Latency is fixed at 1 cycle. There is no backpressure: every accepted request produces exactly one response.
- resp_valid[p] is a single-cycle pulse per request. With back-to-back requests it stays high continuously. When no request is present, resp_valid[p]=0 and the other response fields hold their last values.
- Same-cycle collisions, same local_addr:
  - Read and write on different ports: the read is read-first and returns the old data. The write still takes effect.
  - Two or more writes: the highest port index wins the memory. Every writing port still receives a write acknowledge echoing its own value.
  - Multiple reads: all ports return the same data.
- Width rules: local_addr is used as-is and always lies within DEPTH, so no bounds check is needed. value passes through unmodified. CID_W is $clog2(NCONSUMERS), with a minimum of 1.
- The sequential and combinational logic must remain synthesizable.

Test Plan:
- Init sweep, ADDR_WIDTH=8, NBANKS=4 (DEPTH=64). Release reset, then drive req_valid=2'b11 during INIT -> ready=0 for 64 cycles, rises on the 64th edge; no resp_valid during INIT. Then read addr 63 -> value 0.
- Write then read, port 0. Write {addr=2, value=25, we=1, cid=0}, then next cycle read addr 2 with cid=5 -> cycle N+1: resp_we=1, value=25, cid=0; cycle N+2: resp_we=0, value=25, cid=5.
- Read-first collision. mem[7]=9. Same cycle: port0 writes 7 with value 40, port1 reads 7 -> port1 returns 9. A following read of 7 returns 40.
- Write-write collision. Port0 writes addr 3 with value 11 (cid 1); port1 writes addr 3 with value 22 (cid 2) -> acks carry 11/cid1 and 22/cid2. A subsequent read of 3 returns 22.
- Streaming. Port1 issues 16 consecutive reads of addr 0..15 after writes of value i+100 -> resp_valid[1] is high for 16 consecutive cycles, values 100..115 in order, with 1-cycle latency.
- Reset mid-run. Write addr 4 with value 77, then assert reset for 2 cycles with a read in flight -> resp_valid drops asynchronously and ready=0. After the sweep completes, a read of addr 4 returns 0.
